// File: rtl/bcd_countdown_timer_pkg.sv
// Shared state encoding, BCD limits and load-validity helper for the countdown timer.
package countdown_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] BCD_ZERO     = 8'h00;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // A two-digit BCD field is valid when the units digit is 0..9 and the tens digit is 0..tens_max.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [3:0] tens_max);
    return (val[3:0] <= DIGIT_MAX) && (val[7:4] <= tens_max);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Command/status bundle between the countdown timer and its controller or front panel.
interface bcd_countdown_timer_if;
  logic       ena;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       start;
  logic       pause;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       running;
  logic       done;
  logic       expired;
  logic       load_err;

  modport master (
    output ena, load, load_hh, load_mm, load_ss, start, pause,
    input  hh, mm, ss, running, done, expired, load_err
  );

  modport slave (
    input  ena, load, load_hh, load_mm, load_ss, start, pause,
    output hh, mm, ss, running, done, expired, load_err
  );
endinterface

// File: rtl/bcd_countdown_timer_dec.sv
// Single BCD digit decrementer; a zero digit wraps to wrap_i and borrows from the next digit.
module bcd_digit_dec (
  input  logic [3:0] digit_i,
  input  logic [3:0] wrap_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = wrap_i;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD hh:mm:ss countdown timer with load/start/pause control and expiry reporting.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded value on expiry.
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | decrementing once per ena tick
// PAUSE | suspended, value held, start resumes
// DONE  | expired, holds zero until a valid load
module bcd_countdown_timer (
  input logic            clk,
  input logic            reset_n,
  bcd_countdown_timer_if.slave bus
);
  import countdown_pkg::*;

  localparam logic [23:0] WRAP = {DIGIT_MAX, DIGIT_MAX, SEC_TENS_MAX, DIGIT_MAX, SEC_TENS_MAX, DIGIT_MAX};

  logic [1:0]  state_q, state_d;
  logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        running_q, expired_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [23:0] reload_q, reload_d;
`endif

  logic [23:0] cur_val, dec_val;
  logic [6:0]  borrow;
  logic        dec_expired;
  logic        load_ok;
  logic        cur_zero;

  assign cur_val   = {hh_q, mm_q, ss_q};
  assign cur_zero  = (cur_val == {BCD_ZERO, BCD_ZERO, BCD_ZERO});
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_digit_dec u_dec (
      .digit_i  (cur_val[4*i +: 4]),
      .wrap_i   (WRAP[4*i +: 4]),
      .borrow_i (borrow[i]),
      .digit_o  (dec_val[4*i +: 4]),
      .borrow_o (borrow[i+1])
    );
  end

  // A borrow out of the hours tens digit means the value was already zero; treat it as expiry.
  assign dec_expired = (dec_val == 24'h000000) || borrow[6];

  assign load_ok = bcd_valid(bus.load_hh, DIGIT_MAX)
                && bcd_valid(bus.load_mm, SEC_TENS_MAX)
                && bcd_valid(bus.load_ss, SEC_TENS_MAX);

  always_comb begin
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      if (load_ok) begin
        hh_d    = bus.load_hh;
        mm_d    = bus.load_mm;
        ss_d    = bus.load_ss;
        state_d = ST_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = {bus.load_hh, bus.load_mm, bus.load_ss};
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.start) begin
      if ((state_q == ST_IDLE && !cur_zero) || state_q == ST_PAUSE)
        state_d = ST_RUN;
    end else if (bus.pause) begin
      if (state_q == ST_RUN)
        state_d = ST_PAUSE;
    end else if (bus.ena && state_q == ST_RUN) begin
      if (dec_expired) begin
        done_d = 1'b1;
        {hh_d, mm_d, ss_d} = {BCD_ZERO, BCD_ZERO, BCD_ZERO};
        state_d = ST_DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (reload_q != 24'h000000) begin
          {hh_d, mm_d, ss_d} = reload_q;
          state_d = ST_RUN;
        end
`endif
      end else begin
        {hh_d, mm_d, ss_d} = dec_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hh_q      <= BCD_ZERO;
      mm_q      <= BCD_ZERO;
      ss_q      <= BCD_ZERO;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
      err_q     <= err_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      reload_q <= 24'h000000;
    else
      reload_q <= reload_d;
  end
`endif

  assign bus.hh       = hh_q;
  assign bus.mm       = mm_q;
  assign bus.ss       = ss_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.expired  = expired_q;
  assign bus.load_err = err_q;

endmodule
